// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch FIFO.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0004;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry {pc, instr} prefetch FIFO with synchronous clear; DEPTH must be a power of two.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  if_entry_t                  wdata,
  output if_entry_t                  rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_entry_t       mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/if_fetch_sequencer.sv
// IF-stage fetch controller: PC generation, prefetch queue, ID handshake and EX redirects.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_sequencer
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        misalign
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_state_e       state;
  if_state_e       state_nxt;
  logic [31:0]     pc;
  logic            push;
  logic            pop;
  logic            will_be_full;
  logic            stall_cycle;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  if_entry_t       head;

  if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ('{pc: pc, instr: rom_data}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)  state_nxt = fetch_en ? RUN : IDLE;
    else if (!fetch_en)  state_nxt = IDLE;
    else                 state_nxt = will_be_full ? FULL : RUN;
  end

  // Leaving IDLE pushes on the same edge, so the first fetch lands on the first enabled edge.
  always_comb begin
    pop          = !fifo_empty && id_ready && !redirect_valid;
    push         = fetch_en && !redirect_valid && (!fifo_full || pop);
    will_be_full = fifo_full ? (!pop || push)
                             : (fifo_count == CW'(DEPTH - 1)) && push && !pop;
    stall_cycle  = !redirect_valid && ((state == FULL) || (!fifo_empty && !id_ready));
    if_valid     = !fifo_empty;
    if_instr     = fifo_empty ? '0 : head.instr;
    if_pc        = fifo_empty ? '0 : head.pc;
    rom_addr     = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)        perf_fetched <= perf_fetched + 32'd1;
      if (stall_cycle) perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall_cycle;
`endif

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Randomized scoreboard bench for if_fetch_sequencer with a queue-based reference model.
module tb_if_fetch_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        misalign;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  assign rom_data = rom[rom_addr[7:2]];

  if_fetch_sequencer #(.RESET_PC(32'h0000_0004), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .misalign       (misalign)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] sb [$];
  logic [31:0] mpc = 32'h4;
  int          mcount = 0;
  logic        mmis = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] mfetched = '0;
  logic [31:0] mstall = '0;
  bit          mfull = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mpc = 32'h4; mcount = 0; mmis = 1'b0;
    mfetched = '0; mstall = '0; mfull = 1'b0;
  endtask

  // One clock: drive at negedge, advance the reference model at the following posedge.
  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc,
                      input bit rst_pulse);
    bit pop, push;
    @(negedge clk);
    fetch_en = fe; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (rst_pulse) begin
      rst_n = 1'b0;
      #1;
      model_reset();
    end
    rst_n = 1'b1;
    @(posedge clk);
    if (rv) begin
      sb.delete();
      mcount = 0;
      mpc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) mmis = 1'b1;
      mfull = 1'b0;
    end else begin
      pop  = (mcount > 0) && rdy;
      push = fe && ((mcount < DEPTH) || pop);
      if (mfull || ((mcount > 0) && !rdy)) mstall = mstall + 32'd1;
      if (push) begin
        sb.push_back({mpc, rom[mpc[7:2]]});
        mpc = mpc + 32'd4;
        mfetched = mfetched + 32'd1;
      end
      mcount = mcount + int'(push) - int'(pop);
      mfull = fe && (mcount == DEPTH);
    end
  endtask

  // Monitor: compares presented outputs and every ID handshake against the scoreboard.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        check("rom_addr", {32'h0, rom_addr}, {32'h0, mpc});
        check("if_valid", {63'h0, if_valid}, {63'h0, (mcount > 0)});
        check("misalign", {63'h0, misalign}, {63'h0, mmis});
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", {32'h0, perf_fetched}, {32'h0, mfetched});
        check("perf_stall", {32'h0, perf_stall}, {32'h0, mstall});
`endif
        if (if_valid && id_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_handshake", {32'h0, if_pc}, 64'hffff_ffff_ffff_ffff);
          end else begin
            exp = sb.pop_front();
            check("deliver_pc", {32'h0, if_pc}, {32'h0, exp[63:32]});
            check("deliver_instr", {32'h0, if_instr}, {32'h0, exp[31:0]});
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[1] = 32'h0000_3f37;
    rom[2] = 32'h0200_0fe7;
    rom[9] = 32'h0000_1c63;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", {63'h0, if_valid}, 64'h0);
    check("rst_if_pc", {32'h0, if_pc}, 64'h0);
    check("rst_if_instr", {32'h0, if_instr}, 64'h0);
    check("rst_rom_addr", {32'h0, rom_addr}, 64'h4);
    check("rst_misalign", {63'h0, misalign}, 64'h0);
    chk_en = 1'b1;

    // Bring-up stream with ID always ready.
    step(1, 1, 0, 0, 0); #2;
    check("first_pc", {32'h0, if_pc}, 64'h4);
    check("first_instr", {32'h0, if_instr}, 64'h0000_3f37);
    step(1, 1, 0, 0, 0); #2;
    check("second_pc", {32'h0, if_pc}, 64'h8);
    check("second_instr", {32'h0, if_instr}, 64'h0200_0fe7);

    // Back-pressure from a fresh reset: only 0x4 and 0x8 enter the queue.
    step(1, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0);
    #2;
    check("frozen_addr", {32'h0, rom_addr}, 64'hc);
    check("stalled_head", {32'h0, if_pc}, 64'h4);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0); #2;
    check("no_gap_head", {32'h0, if_pc}, 64'hc);

    // Redirect while 0xc/0x10 are queued.
    step(1, 1, 1, 32'h24, 0); #2;
    check("redir_bubble", {63'h0, if_valid}, 64'h0);
    step(1, 1, 0, 0, 0); #2;
    check("redir_target_pc", {32'h0, if_pc}, 64'h24);
    check("redir_target_instr", {32'h0, if_instr}, 64'h0000_1c63);

    // Misaligned redirect target.
    step(1, 1, 1, 32'h26, 0); #2;
    check("misalign_set", {63'h0, misalign}, 64'h1);
    step(1, 1, 0, 0, 0); #2;
    check("misalign_fetch_pc", {32'h0, if_pc}, 64'h24);
    check("misalign_sticky", {63'h0, misalign}, 64'h1);

    // fetch_en drop: drain, pc holds, then resume.
    held = rom_addr;
    repeat (3) step(0, 1, 0, 0, 0);
    #2;
    check("drain_empty", {63'h0, if_valid}, 64'h0);
    check("drain_pc_held", {32'h0, rom_addr}, {32'h0, held});
    step(1, 1, 0, 0, 0); #2;
    check("resume_pc", {32'h0, if_pc}, {32'h0, held});

    // Randomized traffic, including held redirects and occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0,
           $urandom_range(0, 255), ($urandom % 600) == 0);
    end

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
